// File: rtl/rs_alu_pkg.sv
// Shared types for the ALU reservation station.
// Entry layout, op encodings and the wakeup helper.
package rs_alu_pkg;

    localparam int GPR_SIZE     = 64;
    localparam int ROB_IDX_SIZE = 5;

    typedef enum logic [3:0] {
        FU_OP_PASS_A = 4'd0,
        FU_OP_PASS_B = 4'd1,
        FU_OP_PLUS   = 4'd2,
        FU_OP_MINUS  = 4'd3,
        FU_OP_AND    = 4'd4,
        FU_OP_ORR    = 4'd5,
        FU_OP_EOR    = 4'd6,
        FU_OP_CSEL   = 4'd7
    } fu_op_t;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic                    valid;
        fu_op_t                  fu_op;
        logic [GPR_SIZE-1:0]     val_a;
        logic [GPR_SIZE-1:0]     val_b;
        logic                    a_ready;
        logic                    b_ready;
        logic [ROB_IDX_SIZE-1:0] a_tag;
        logic [ROB_IDX_SIZE-1:0] b_tag;
        logic [ROB_IDX_SIZE-1:0] dst;
        logic                    set_nzcv;
        nzcv_t                   nzcv;
        logic                    nzcv_ready;
        logic [ROB_IDX_SIZE-1:0] nzcv_tag;
    } rs_entry_t;

    // Only pending fields of a valid entry may capture the broadcast.
    function automatic rs_entry_t rs_wake(
        input rs_entry_t                e,
        input logic                     done,
        input logic [ROB_IDX_SIZE-1:0]  tag,
        input logic [GPR_SIZE-1:0]      value,
        input logic                     set_nzcv,
        input nzcv_t                    nzcv
    );
        rs_entry_t r;
        r = e;
        if (done && e.valid) begin
            if (!e.a_ready && e.a_tag == tag) begin
                r.val_a   = value;
                r.a_ready = 1'b1;
            end
            if (!e.b_ready && e.b_tag == tag) begin
                r.val_b   = value;
                r.b_ready = 1'b1;
            end
            if (set_nzcv && !e.nzcv_ready && e.nzcv_tag == tag) begin
                r.nzcv       = nzcv;
                r.nzcv_ready = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_alu_select.sv
// Priority picker: lowest-index ready entry.
// found is low when no entry is ready.
module rs_select
    import rs_alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         ready,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int W = $clog2(N);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ready[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: collapsing queue, oldest-ready issue.
// Snoops the FU result broadcast to wake pending operands.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = 4
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic                    in_dispatch_valid,
    input  fu_op_t                  in_dispatch_fu_op,
    input  logic [GPR_SIZE-1:0]     in_dispatch_val_a,
    input  logic [GPR_SIZE-1:0]     in_dispatch_val_b,
    input  logic                    in_dispatch_a_ready,
    input  logic                    in_dispatch_b_ready,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
    input  logic                    in_dispatch_set_nzcv,
    input  nzcv_t                   in_dispatch_nzcv,
    input  logic                    in_dispatch_nzcv_ready,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_rob_index,
    output logic                    out_dispatch_ready,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
    input  logic [GPR_SIZE-1:0]     in_fu_value,
    input  logic                    in_fu_set_nzcv,
    input  nzcv_t                   in_fu_nzcv,
    input  logic                    in_fu_alu_ready,
    output logic                    out_fu_alu_start,
    output fu_op_t                  out_fu_alu_fu_op,
    output logic [GPR_SIZE-1:0]     out_fu_alu_val_a,
    output logic [GPR_SIZE-1:0]     out_fu_alu_val_b,
    output logic [ROB_IDX_SIZE-1:0] out_fu_alu_dst_rob_index,
    output logic                    out_fu_alu_set_nzcv,
    output nzcv_t                   out_fu_alu_nzcv
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    rs_entry_t          q     [RS_SIZE];
    rs_entry_t          nq    [RS_SIZE];
    rs_entry_t          w     [RS_SIZE+1];
    rs_entry_t          dent;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   next_count;
    logic [CNT_W-1:0]   slot;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               issue;
    logic               accept;

    assign out_dispatch_ready = (count < CNT_W'(RS_SIZE));

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = q[i].valid & q[i].a_ready
                         & q[i].b_ready & q[i].nzcv_ready;
        end
    end

    rs_select #(.N(RS_SIZE)) u_select (
        .ready (ready_vec),
        .idx   (sel),
        .found (found)
    );

    assign issue  = found & in_fu_alu_ready & ~in_flush & ~in_rst;
    assign accept = in_dispatch_valid & out_dispatch_ready
                  & ~in_flush & ~in_rst;

    always_comb begin
        dent            = '0;
        dent.valid      = 1'b1;
        dent.fu_op      = in_dispatch_fu_op;
        dent.val_a      = in_dispatch_val_a;
        dent.val_b      = in_dispatch_val_b;
        dent.a_ready    = in_dispatch_a_ready;
        dent.b_ready    = in_dispatch_b_ready;
        dent.a_tag      = in_dispatch_a_rob_index;
        dent.b_tag      = in_dispatch_b_rob_index;
        dent.dst        = in_dispatch_dst_rob_index;
        dent.set_nzcv   = in_dispatch_set_nzcv;
        dent.nzcv       = in_dispatch_nzcv;
        dent.nzcv_ready = in_dispatch_nzcv_ready;
        dent.nzcv_tag   = in_dispatch_nzcv_rob_index;
        dent = rs_wake(dent, in_fu_done, in_fu_dst_rob_index,
                       in_fu_value, in_fu_set_nzcv, in_fu_nzcv);
    end

    // Wake every slot, then collapse over the issued slot.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w[i] = rs_wake(q[i], in_fu_done, in_fu_dst_rob_index,
                           in_fu_value, in_fu_set_nzcv, in_fu_nzcv);
        end
        w[RS_SIZE] = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (issue && i >= int'(sel)) nq[i] = w[i+1];
            else                         nq[i] = w[i];
        end
        slot = count - CNT_W'(issue);
        if (accept) nq[slot[IDX_W-1:0]] = dent;
        next_count = count - CNT_W'(issue) + CNT_W'(accept);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < RS_SIZE; i++) q[i] <= '0;
            count                    <= '0;
            out_fu_alu_start         <= 1'b0;
            out_fu_alu_fu_op         <= FU_OP_PASS_A;
            out_fu_alu_val_a         <= '0;
            out_fu_alu_val_b         <= '0;
            out_fu_alu_dst_rob_index <= '0;
            out_fu_alu_set_nzcv      <= 1'b0;
            out_fu_alu_nzcv          <= '0;
        end else if (in_flush) begin
            for (int i = 0; i < RS_SIZE; i++) q[i] <= '0;
            count            <= '0;
            out_fu_alu_start <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) q[i] <= nq[i];
            count            <= next_count;
            out_fu_alu_start <= issue;
            if (issue) begin
                out_fu_alu_fu_op         <= q[sel].fu_op;
                out_fu_alu_val_a         <= q[sel].val_a;
                out_fu_alu_val_b         <= q[sel].val_b;
                out_fu_alu_dst_rob_index <= q[sel].dst;
                out_fu_alu_set_nzcv      <= q[sel].set_nzcv;
                out_fu_alu_nzcv          <= q[sel].nzcv;
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu.
// Scoreboard of expected issues plus directed timing checks.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst = 1'b1, flush = 1'b0;
    logic                    d_valid = 1'b0;
    fu_op_t                  d_op = FU_OP_PASS_A;
    logic [GPR_SIZE-1:0]     d_a = '0, d_b = '0;
    logic                    d_ar = 1'b0, d_br = 1'b0;
    logic [ROB_IDX_SIZE-1:0] d_atag = '0, d_btag = '0, d_dst = '0;
    logic                    d_sn = 1'b0;
    nzcv_t                   d_n = '0;
    logic                    d_nr = 1'b0;
    logic [ROB_IDX_SIZE-1:0] d_ntag = '0;
    logic                    disp_rdy;
    logic                    fu_done = 1'b0;
    logic [ROB_IDX_SIZE-1:0] fu_tag = '0;
    logic [GPR_SIZE-1:0]     fu_val = '0;
    logic                    fu_sn = 1'b0;
    nzcv_t                   fu_n = '0;
    logic                    alu_rdy = 1'b1;
    logic                    start;
    fu_op_t                  o_op;
    logic [GPR_SIZE-1:0]     o_a, o_b;
    logic [ROB_IDX_SIZE-1:0] o_dst;
    logic                    o_sn;
    nzcv_t                   o_n;

    rs_alu #(.RS_SIZE(4)) dut (
        .in_clk                     (clk),
        .in_rst                     (rst),
        .in_flush                   (flush),
        .in_dispatch_valid          (d_valid),
        .in_dispatch_fu_op          (d_op),
        .in_dispatch_val_a          (d_a),
        .in_dispatch_val_b          (d_b),
        .in_dispatch_a_ready        (d_ar),
        .in_dispatch_b_ready        (d_br),
        .in_dispatch_a_rob_index    (d_atag),
        .in_dispatch_b_rob_index    (d_btag),
        .in_dispatch_dst_rob_index  (d_dst),
        .in_dispatch_set_nzcv       (d_sn),
        .in_dispatch_nzcv           (d_n),
        .in_dispatch_nzcv_ready     (d_nr),
        .in_dispatch_nzcv_rob_index (d_ntag),
        .out_dispatch_ready         (disp_rdy),
        .in_fu_done                 (fu_done),
        .in_fu_dst_rob_index        (fu_tag),
        .in_fu_value                (fu_val),
        .in_fu_set_nzcv             (fu_sn),
        .in_fu_nzcv                 (fu_n),
        .in_fu_alu_ready            (alu_rdy),
        .out_fu_alu_start           (start),
        .out_fu_alu_fu_op           (o_op),
        .out_fu_alu_val_a           (o_a),
        .out_fu_alu_val_b           (o_b),
        .out_fu_alu_dst_rob_index   (o_dst),
        .out_fu_alu_set_nzcv        (o_sn),
        .out_fu_alu_nzcv            (o_n)
    );

    typedef struct {
        fu_op_t                  op;
        logic [GPR_SIZE-1:0]     a;
        logic [GPR_SIZE-1:0]     b;
        logic [ROB_IDX_SIZE-1:0] dst;
        logic                    sn;
        nzcv_t                   n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && start) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_op", 64'(o_op), 64'(e.op));
                check("issue_a", o_a, e.a);
                check("issue_b", o_b, e.b);
                check("issue_dst", 64'(o_dst), 64'(e.dst));
                check("issue_sn", 64'(o_sn), 64'(e.sn));
                check("issue_nzcv", 64'(o_n), 64'(e.n));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input fu_op_t op,
                        input logic [63:0] a, input logic ar,
                        input logic [4:0] atag,
                        input logic [63:0] b, input logic br,
                        input logic [4:0] btag,
                        input logic [4:0] dst, input logic sn,
                        input nzcv_t n, input logic nr,
                        input logic [4:0] ntag);
        d_valid = 1'b1; d_op = op;
        d_a = a; d_ar = ar; d_atag = atag;
        d_b = b; d_br = br; d_btag = btag;
        d_dst = dst; d_sn = sn;
        d_n = n; d_nr = nr; d_ntag = ntag;
    endtask

    task automatic push(input fu_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] dst,
                        input logic sn, input nzcv_t n);
        exp_t e;
        e.op = op; e.a = a; e.b = b;
        e.dst = dst; e.sn = sn; e.n = n;
        sb.push_back(e);
    endtask

    task automatic bcast(input logic [4:0] tag, input logic [63:0] v,
                         input logic sn, input nzcv_t n);
        fu_done = 1'b1; fu_tag = tag;
        fu_val = v; fu_sn = sn; fu_n = n;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("rst_start", 64'(start), 64'd0);
        check("rst_disp_rdy", 64'(disp_rdy), 64'd1);
        check("rst_op", 64'(o_op), 64'(FU_OP_PASS_A));
        check("rst_a", o_a, 64'd0);
        check("rst_dst", 64'(o_dst), 64'd0);

        // ADD ready on dispatch
        disp(FU_OP_PLUS, 5, 1, 0, 7, 1, 0, 3, 0, 0, 1, 0);
        push(FU_OP_PLUS, 5, 7, 3, 0, 0);
        tick(); d_valid = 1'b0;
        check("add_latency", 64'(start), 64'd0);
        tick();
        check("add_start", 64'(start), 64'd1);
        tick();
        check("add_one_cycle", 64'(start), 64'd0);

        // SUB with a pending on tag 2
        disp(FU_OP_MINUS, 0, 0, 2, 1, 1, 0, 4, 0, 0, 1, 0);
        push(FU_OP_MINUS, 40, 1, 4, 0, 0);
        tick(); d_valid = 1'b0;
        tick();
        check("sub_wait", 64'(start), 64'd0);
        bcast(2, 40, 0, 0);
        tick(); fu_done = 1'b0;
        check("sub_wake_lat", 64'(start), 64'd0);
        tick();
        check("sub_start", 64'(start), 64'd1);
        tick();

        // CSEL waits for flags, ignores non-flag broadcast
        disp(FU_OP_CSEL, 10, 1, 0, 20, 1, 0, 5, 0, 0, 0, 6);
        push(FU_OP_CSEL, 10, 20, 5, 0, 4'b0100);
        tick(); d_valid = 1'b0;
        bcast(6, 999, 0, 4'b1111);
        tick(); fu_done = 1'b0;
        tick();
        check("csel_no_flags", 64'(start), 64'd0);
        tick();
        check("csel_still", 64'(start), 64'd0);
        bcast(6, 0, 1, 4'b0100);
        tick(); fu_done = 1'b0;
        tick();
        check("csel_start", 64'(start), 64'd1);
        tick();

        // fill, drop fifth, drain in order
        alu_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(FU_OP_PLUS, 64'(100 + i), 1, 0, 1, 1, 0,
                 5'(i), 0, 0, 1, 0);
            push(FU_OP_PLUS, 64'(100 + i), 1, 5'(i), 0, 0);
            tick();
        end
        check("full_disp_rdy", 64'(disp_rdy), 64'd0);
        disp(FU_OP_PLUS, 555, 1, 0, 1, 1, 0, 7, 0, 0, 1, 0);
        tick(); d_valid = 1'b0;
        check("full_no_issue", 64'(start), 64'd0);
        check("full_still", 64'(disp_rdy), 64'd0);
        alu_rdy = 1'b1;
        tick();
        check("drain_start", 64'(start), 64'd1);
        check("drain_first", 64'(o_dst), 64'd0);
        tick(); tick(); tick();
        check("drain_last", 64'(o_dst), 64'd3);
        tick();
        check("drain_done", 64'(start), 64'd0);
        check("drain_rdy", 64'(disp_rdy), 64'd1);

        // dispatch and matching broadcast in the same cycle
        disp(FU_OP_PLUS, 0, 0, 9, 1, 1, 0, 6, 0, 0, 1, 0);
        bcast(9, 123, 0, 0);
        push(FU_OP_PLUS, 123, 1, 6, 0, 0);
        tick(); d_valid = 1'b0; fu_done = 1'b0;
        check("cap_latency", 64'(start), 64'd0);
        tick();
        check("cap_start", 64'(start), 64'd1);
        tick();

        // flush with a full station
        alu_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(FU_OP_AND, 64'(i), 1, 0, 1, 1, 0,
                 5'(10 + i), 0, 0, 1, 0);
            tick();
        end
        d_valid = 1'b0;
        check("pre_flush_rdy", 64'(disp_rdy), 64'd0);
        flush = 1'b1;
        tick(); flush = 1'b0;
        check("flush_rdy", 64'(disp_rdy), 64'd1);
        check("flush_start", 64'(start), 64'd0);
        alu_rdy = 1'b1;
        tick(); tick();
        check("flush_empty", 64'(start), 64'd0);

        // reset mid-operation
        alu_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            disp(FU_OP_ORR, 64'(i), 1, 0, 1, 1, 0,
                 5'(20 + i), 0, 0, 1, 0);
            tick();
        end
        d_valid = 1'b0;
        rst = 1'b1;
        tick(); rst = 1'b0;
        check("mrst_rdy", 64'(disp_rdy), 64'd1);
        check("mrst_start", 64'(start), 64'd0);
        check("mrst_a", o_a, 64'd0);
        check("mrst_dst", 64'(o_dst), 64'd0);
        alu_rdy = 1'b1;
        tick(); tick();
        check("mrst_empty", 64'(start), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
